seq_multiplier: RTL

- Sequential shift-and-add unsigned multiplier. It is the inverse-direction companion to the team's combinational divider, used for percentage and scaling of vote tallies (e.g. quotient × 100).
- Takes two WIDTH-bit operands on a start pulse and retires one multiplier bit per clock.
- Presents a registered 2*WIDTH-bit product with a one-cycle done pulse and an overflow flag for WIDTH-bit truncation.
- Sits between the tally counters and the display/percentage path.

---
 rtl/seq_multiplier_pkg.sv | 13 +
 rtl/seq_multiplier_if.sv | 18 +
 rtl/seq_multiplier.sv | 87 ++++++++
 3 files changed

// File: rtl/seq_multiplier_pkg.sv
// Shared constants and state encoding for the sequential multiplier.
// DEFAULT_WIDTH is the same operand width the divider uses.
package seq_multiplier_pkg;

    localparam int unsigned DEFAULT_WIDTH = 7;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_t;

endpackage

// File: rtl/seq_multiplier_if.sv
// Request/result bundle for seq_multiplier. The master issues operands, and the
// slave (the multiplier) returns busy, done, the product and the overflow flag.
interface seq_multiplier_if
    import seq_multiplier_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);
    logic               start;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] Res;
    logic               ovf;

    modport master (output start, A, B, input busy, done, Res, ovf);
    modport slave  (input start, A, B, output busy, done, Res, ovf);
endinterface

// File: rtl/seq_multiplier.sv
// Shift-and-add unsigned multiplier: one multiplier bit per clock, WIDTH RUN cycles,
// then a one-cycle done pulse with the registered product and truncation overflow.
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input logic             clk,
    input logic             rst,
    seq_multiplier_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    state_t               state;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [CntW-1:0]      cnt;
    logic                 busy_q;
    logic                 done_q;
    logic [2*WIDTH-1:0]   res_q;
    logic                 ovf_q;
    logic [2*WIDTH-1:0]   acc_nxt;

    // Accumulator value after this cycle's step; also the final product on the last step.
    always_comb begin
        acc_nxt = acc;
        if (mplier[0]) begin
            acc_nxt = acc + mcand;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= StIdle;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            res_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (bus.start) begin
                        mcand  <= {{WIDTH{1'b0}}, bus.A};
                        mplier <= bus.B;
                        acc    <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= StRun;
                    end
                end
                StRun: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LastCnt) begin
                        res_q  <= acc_nxt;
                        ovf_q  <= |acc_nxt[2*WIDTH-1:WIDTH];
                        done_q <= 1'b1;
                        state  <= StDone;
                    end
                end
                StDone: begin
                    busy_q <= 1'b0;
                    state  <= StIdle;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= StIdle;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.Res  = res_q;
    assign bus.ovf  = ovf_q;

endmodule
